// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the iterative divider.
//   DIV_W       data width of dividend/divisor (32)
//   DIV_CYCLES  number of restoring steps per division (32)
//   div_state_e FSM encoding: DIV_IDLE, DIV_ZERO, DIV_BUSY, DIV_DONE
//   abs_val()   magnitude of an operand (only when signed mode is selected)
//   neg_if()    conditional two's-complement negation for sign fix-up
package div_unit_pkg;

   localparam int unsigned DIV_W      = 32;
   localparam int unsigned DIV_CYCLES = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ZERO = 2'd1,
      DIV_BUSY = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   // 0x80000000 maps to itself, which read as unsigned is the correct magnitude.
   function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] x, input logic is_signed);
      return (is_signed && x[DIV_W-1]) ? -x : x;
   endfunction

   function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit radix-2 restoring divider for the EX stage.
// Optional feature macro: DIV_ANNUL_EN (adds the annul input).
// Ports:
//   clk         pipeline clock
//   rst         asynchronous active-high reset
//   div_valid   division request (sampled in IDLE only)
//   signed_div  1 = DIV (signed), 0 = DIVU; sampled with div_valid
//   opa, opb    dividend (rs) and divisor (rt)
//   annul       cancel in-flight division (only with DIV_ANNUL_EN)
//   result      {remainder, quotient}: [63:32] -> HI, [31:0] -> LO
//   ready       one-cycle pulse, result valid
//   stall_div   hold IF/ID/EX while the division is pending
module div_unit
   import div_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 div_valid,
   input  logic                 signed_div,
   input  logic [DIV_W-1:0]     opa,
   input  logic [DIV_W-1:0]     opb,
`ifdef DIV_ANNUL_EN
   input  logic                 annul,
`endif
   output logic [2*DIV_W-1:0]   result,
   output logic                 ready,
   output logic                 stall_div
);

   div_state_e            state_q, state_d;
   logic [5:0]            cnt_q, cnt_d;
   // {rem[32:0], quo[31:0]}
   logic [2*DIV_W:0]      work_q, work_d;
   logic [DIV_W-1:0]      dvsr_q, dvsr_d;
   logic                  neg_quo_q, neg_quo_d;
   logic                  neg_rem_q, neg_rem_d;
   logic [2*DIV_W-1:0]    result_q, result_d;

   logic                  annul_w;
   logic [2*DIV_W:0]      shifted;
   logic [DIV_W:0]        diff;
   logic [2*DIV_W:0]      step;
   logic [2*DIV_W-1:0]    fixed;

`ifdef DIV_ANNUL_EN
   assign annul_w = annul;
`else
   assign annul_w = 1'b0;
`endif

   // One restoring step: shift, trial-subtract, keep difference if non-negative.
   always_comb begin
      shifted = work_q << 1;
      diff    = shifted[2*DIV_W:DIV_W] - {1'b0, dvsr_q};
      if (diff[DIV_W]) begin
         step = shifted;
      end else begin
         step = {diff, shifted[DIV_W-1:1], 1'b1};
      end
   end

   // Remainder fits in 32 bits once all steps are done, so work_q[64] is always 0 here.
   assign fixed = {neg_if(work_q[2*DIV_W-1:DIV_W], neg_rem_q),
                   neg_if(work_q[DIV_W-1:0], neg_quo_q)};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      dvsr_d    = dvsr_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      ready     = 1'b0;
      stall_div = 1'b0;

      unique case (state_q)
         DIV_IDLE: begin
            if (div_valid && !annul_w) begin
               stall_div = 1'b1;
               dvsr_d    = abs_val(opb, signed_div);
               work_d    = {{(DIV_W+1){1'b0}}, abs_val(opa, signed_div)};
               neg_quo_d = signed_div && (opa[DIV_W-1] ^ opb[DIV_W-1]);
               neg_rem_d = signed_div && opa[DIV_W-1];
               cnt_d     = '0;
               state_d   = (opb == '0) ? DIV_ZERO : DIV_BUSY;
            end
         end
         DIV_ZERO: begin
            state_d = DIV_IDLE;
            if (!annul_w) begin
               ready    = 1'b1;
               result_d = '0;
            end
         end
         DIV_BUSY: begin
            stall_div = 1'b1;
            if (annul_w) begin
               state_d = DIV_IDLE;
            end else begin
               work_d = step;
               cnt_d  = cnt_q + 6'd1;
               if (cnt_q == 6'(DIV_CYCLES - 1)) begin
                  state_d = DIV_DONE;
               end
            end
         end
         DIV_DONE: begin
            // annul is deliberately ignored here: the result is already committed.
            ready    = 1'b1;
            result_d = fixed;
            state_d  = DIV_IDLE;
         end
         default: begin
            state_d = DIV_IDLE;
         end
      endcase
   end

   // New result is visible combinationally in the ready cycle, then held.
   assign result = ready ? result_d : result_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= DIV_IDLE;
         cnt_q     <= '0;
         work_q    <= '0;
         dvsr_q    <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         dvsr_q    <= dvsr_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

endmodule
